operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 119 +++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: register file with writeback bypass, a pending-write
// scoreboard for RAW/WAW hazard detection, and a one-entry output register
// with valid/ready handshake toward the ALU.
module operand_fetch (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    input  logic        in_use_imm,
    input  logic [3:0]  in_func,
    input  logic        in_wen,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [3:0]  out_func,
    output logic [4:0]  out_rd,
    output logic        out_wen,

    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data
);

    // x0 is not stored; reads of index 0 are forced to zero.
    logic [31:0] rf [1:31];
    logic [31:0] pending;

    logic        wb_write;
    logic [31:0] wb_mask;
    logic [31:0] set_mask;
    logic [31:0] pend_eff;
    logic        hazard;
    logic        accept;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] opb_val;

    // Writeback decode and scoreboard masks; a register being written back
    // this cycle no longer counts as pending for hazard purposes.
    always_comb begin
        wb_write = wb_valid && (wb_rd != 5'd0);
        wb_mask  = wb_valid ? (32'd1 << wb_rd) : '0;
        pend_eff = pending & ~wb_mask;
        hazard   = in_valid && (pend_eff[in_rs1] ||
                                (!in_use_imm && pend_eff[in_rs2]) ||
                                (in_wen && pend_eff[in_rd]));
        in_ready = (!out_valid || out_ready) && !hazard;
        accept   = in_valid && in_ready;
        set_mask = (accept && in_wen && (in_rd != 5'd0)) ? (32'd1 << in_rd) : '0;
    end

    // Source operand reads with writeback bypass and hardwired x0.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (in_rs1 != 5'd0) begin
            if (wb_write && (wb_rd == in_rs1))
                rs1_val = wb_data;
            else
                rs1_val = rf[in_rs1];
        end
        if (in_rs2 != 5'd0) begin
            if (wb_write && (wb_rd == in_rs2))
                rs2_val = wb_data;
            else
                rs2_val = rf[in_rs2];
        end
        opb_val = in_use_imm ? in_imm : rs2_val;
    end

    // Register file writeback port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < 32; i++)
                rf[i] <= '0;
        end else if (wb_write) begin
            rf[wb_rd] <= wb_data;
        end
    end

    // Scoreboard: clear on writeback, then set on issue so a same-cycle
    // set of the same bit wins; bit 0 is kept at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= ((pending & ~wb_mask) | set_mask) & ~32'd1;
    end

    // Output packet register: load on accept, drop valid when consumed,
    // hold everything while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_func  <= '0;
            out_rd    <= '0;
            out_wen   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_a     <= rs1_val;
            out_b     <= opb_val;
            out_func  <= in_func;
            out_rd    <= in_rd;
            out_wen   <= in_wen;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
